// File: rtl/qa_7seg_arbiter.sv
// qa_7seg_arbiter: round-robin arbiter that hands a shared 7-segment display
// to one of three requesters. Each requester owns the display for a minimum
// dwell time. Digit data and digit-pair enables are registered for the driver.
module qa_7seg_arbiter #(
    parameter int unsigned DWELL_CYCLES = 50000000
) (
    input  logic        clkIn,
    input  logic        rstIn,
    input  logic [2:0]  reqIn,
    input  logic [71:0] dataIn,
    input  logic [11:0] enableIn,
    output logic [23:0] dataOut,
    output logic [3:0]  enableOut,
    output logic [2:0]  grantOut,
    output logic        busyOut
);

    typedef enum logic {IDLE, HOLD} state_t;

    // Final dwell count. The owner may be displaced once the counter reaches it.
    localparam logic [25:0] DWELL_LAST = 26'(DWELL_CYCLES - 1);

    // Modulo-3 increment of a requester index.
    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    // Round-robin pick: the first set bit of mask, searching from last+1 and wrapping.
    function automatic logic [1:0] rr_pick(input logic [2:0] mask, input logic [1:0] last);
        logic [1:0] s1;
        logic [1:0] s2;
        logic [1:0] s3;
        s1 = inc3(last);
        s2 = inc3(s1);
        s3 = inc3(s2);
        if (mask[s1])      return s1;
        else if (mask[s2]) return s2;
        else               return s3;
    endfunction

    // Saturating dwell counter step.
    function automatic logic [25:0] dwell_step(input logic [25:0] c);
        return (c >= DWELL_LAST) ? DWELL_LAST : c + 26'd1;
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  last_q, last_d;     // last granted index; this is the owner while in HOLD
    logic [25:0] cnt_q, cnt_d;
    logic [2:0]  mask;
    logic [1:0]  pick;
    logic        expired;
    logic [23:0] data_d;
    logic [3:0]  en_d;
    logic [2:0]  grant_d;

    // Next-state logic: grant, dwell counter and pointer update.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        // The owner's own bit is excluded, so it is never picked against itself.
        mask    = reqIn & ~grantOut;
        pick    = rr_pick(mask, last_q);
        expired = (cnt_q == DWELL_LAST);
        case (state_q)
            IDLE: begin
                if (|reqIn) begin
                    state_d = HOLD;
                    last_d  = pick;
                    cnt_d   = 26'd0;
                end
            end
            HOLD: begin
                if (!reqIn[last_q]) begin
                    // The owner released the display: hand over or go idle.
                    cnt_d = 26'd0;
                    if (|mask) last_d  = pick;
                    else       state_d = IDLE;
                end else if (expired && (|mask)) begin
                    last_d = pick;
                    cnt_d  = 26'd0;
                end else begin
                    cnt_d = dwell_step(cnt_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output selection: the next owner's slices, or blank when idle.
    always_comb begin
        data_d  = 24'd0;
        en_d    = 4'd0;
        grant_d = 3'd0;
        if (state_d == HOLD) begin
            grant_d = 3'b001 << last_d;
            case (last_d)
                2'd0:    begin data_d = dataIn[23:0];  en_d = enableIn[3:0];  end
                2'd1:    begin data_d = dataIn[47:24]; en_d = enableIn[7:4];  end
                default: begin data_d = dataIn[71:48]; en_d = enableIn[11:8]; end
            endcase
        end
    end

    // State, pointer, counter and output registers. The pointer resets to 2 so requester 0 wins first.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            state_q   <= IDLE;
            last_q    <= 2'd2;
            cnt_q     <= 26'd0;
            grantOut  <= 3'd0;
            dataOut   <= 24'd0;
            enableOut <= 4'd0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            grantOut  <= grant_d;
            dataOut   <= data_d;
            enableOut <= en_d;
        end
    end

    assign busyOut = |grantOut;

endmodule

// File: tb/tb_qa_7seg_arbiter.sv
// Directed testbench for qa_7seg_arbiter with DWELL_CYCLES=4, plus a second
// instance with DWELL_CYCLES=1 for per-cycle round robin.
module tb_qa_7seg_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = 3'd0;
    logic [23:0] d0 = 24'd0, d1 = 24'd0, d2 = 24'd0;
    logic [3:0]  e0 = 4'd0, e1 = 4'd0, e2 = 4'd0;
    logic [71:0] data_in;
    logic [11:0] en_in;

    logic [23:0] data_out, data_out1;
    logic [3:0]  en_out, en_out1;
    logic [2:0]  grant, grant1;
    logic        busy, busy1;

    int checks = 0;
    int errors = 0;

    assign data_in = {d2, d1, d0};
    assign en_in   = {e2, e1, e0};

    always #5 clk = ~clk;

    qa_7seg_arbiter #(.DWELL_CYCLES(4)) u_dut (
        .clkIn(clk), .rstIn(rst), .reqIn(req), .dataIn(data_in), .enableIn(en_in),
        .dataOut(data_out), .enableOut(en_out), .grantOut(grant), .busyOut(busy)
    );

    qa_7seg_arbiter #(.DWELL_CYCLES(1)) u_dut1 (
        .clkIn(clk), .rstIn(rst), .reqIn(req), .dataIn(data_in), .enableIn(en_in),
        .dataOut(data_out1), .enableOut(en_out1), .grantOut(grant1), .busyOut(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 3'd0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 3'b111;
        d0 = 24'hABCDEF; e0 = 4'hF;
        tick();
        tick();
        checks++; if (grant !== 3'd0)    begin errors++; $display("FAIL reset_grant got %b want 000", grant); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (data_out !== 24'd0) begin errors++; $display("FAIL reset_data got %h want 000000", data_out); end
        checks++; if (en_out !== 4'd0)   begin errors++; $display("FAIL reset_en got %h want 0", en_out); end
        rst = 1'b0;
        req = 3'd0;
    endtask

    task automatic test_single_grant();
        do_reset();
        d0 = 24'h123456; e0 = 4'hF;
        d1 = 24'h999999; e1 = 4'h5;
        d2 = 24'h777777; e2 = 4'hA;
        req = 3'b001;
        tick();
        checks++; if (grant !== 3'b001)      begin errors++; $display("FAIL single_grant got %b want 001", grant); end
        checks++; if (busy !== 1'b1)         begin errors++; $display("FAIL single_busy got %b want 1", busy); end
        checks++; if (data_out !== 24'h123456) begin errors++; $display("FAIL single_data got %h want 123456", data_out); end
        checks++; if (en_out !== 4'hF)       begin errors++; $display("FAIL single_en got %h want f", en_out); end
    endtask

    task automatic test_round_robin();
        logic [2:0]  exp_g;
        logic [23:0] exp_d;
        logic [3:0]  exp_e;
        do_reset();
        d0 = 24'h111111; e0 = 4'h1;
        d1 = 24'h222222; e1 = 4'h2;
        d2 = 24'h333333; e2 = 4'h4;
        req = 3'b111;
        for (int c = 0; c < 16; c++) begin
            tick();
            case ((c / 4) % 3)
                0:       begin exp_g = 3'b001; exp_d = 24'h111111; exp_e = 4'h1; end
                1:       begin exp_g = 3'b010; exp_d = 24'h222222; exp_e = 4'h2; end
                default: begin exp_g = 3'b100; exp_d = 24'h333333; exp_e = 4'h4; end
            endcase
            checks++; if (grant !== exp_g)    begin errors++; $display("FAIL rr_grant cycle %0d got %b want %b", c, grant, exp_g); end
            checks++; if (data_out !== exp_d) begin errors++; $display("FAIL rr_data cycle %0d got %h want %h", c, data_out, exp_d); end
            checks++; if (en_out !== exp_e)   begin errors++; $display("FAIL rr_en cycle %0d got %h want %h", c, en_out, exp_e); end
            checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL rr_busy cycle %0d got %b want 1", c, busy); end
        end
    endtask

    task automatic test_owner_drop();
        do_reset();
        d0 = 24'h0A0A0A; e0 = 4'h3;
        d1 = 24'h0B0B0B; e1 = 4'hC;
        req = 3'b001;
        tick();                         // owned cycle 0
        req = 3'b011;
        tick();                         // owned cycle 1
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL drop_hold1 got %b want 001", grant); end
        tick();                         // owned cycle 2
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL drop_hold2 got %b want 001", grant); end
        req = 3'b010;
        tick();
        checks++; if (grant !== 3'b010)        begin errors++; $display("FAIL drop_switch got %b want 010", grant); end
        checks++; if (data_out !== 24'h0B0B0B) begin errors++; $display("FAIL drop_data got %h want 0b0b0b", data_out); end
        // Counter restarted: requester 1 keeps the display for a full dwell against requester 0.
        req = 3'b011;
        for (int c = 1; c < 4; c++) begin
            tick();
            checks++; if (grant !== 3'b010) begin errors++; $display("FAIL drop_dwell cycle %0d got %b want 010", c, grant); end
        end
        tick();
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL drop_expire got %b want 001", grant); end
    endtask

    task automatic test_single_owner();
        logic [23:0] sent;
        do_reset();
        e2 = 4'h6;
        req = 3'b100;
        for (int k = 0; k < 10; k++) begin
            sent = 24'hC00000 + 24'(k * 3);
            d2 = sent;
            e0 = 4'(k);                 // non-granted enables must not leak out
            tick();
            checks++; if (grant !== 3'b100) begin errors++; $display("FAIL solo_grant cycle %0d got %b want 100", k, grant); end
            checks++; if (data_out !== sent) begin errors++; $display("FAIL solo_data cycle %0d got %h want %h", k, data_out, sent); end
            checks++; if (en_out !== 4'h6)  begin errors++; $display("FAIL solo_en cycle %0d got %h want 6", k, en_out); end
            d2 = 24'hFFFFFF;            // output must reflect the value at the edge, not after it
            #1;
            checks++; if (data_out !== sent) begin errors++; $display("FAIL solo_lag cycle %0d got %h want %h", k, data_out, sent); end
        end
    endtask

    task automatic test_all_drop();
        req = 3'b000;
        tick();
        checks++; if (grant !== 3'd0)     begin errors++; $display("FAIL idle_grant got %b want 000", grant); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
        checks++; if (data_out !== 24'd0) begin errors++; $display("FAIL idle_data got %h want 000000", data_out); end
        checks++; if (en_out !== 4'd0)    begin errors++; $display("FAIL idle_en got %h want 0", en_out); end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        d1 = 24'h515151; e1 = 4'h9;
        req = 3'b011;
        tick();
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL mid_first got %b want 001", grant); end
        req = 3'b010;
        tick();
        req = 3'b011;
        tick();
        checks++; if (grant !== 3'b010) begin errors++; $display("FAIL mid_owner got %b want 010", grant); end
        rst = 1'b1;
        tick();
        checks++; if (grant !== 3'd0)     begin errors++; $display("FAIL mid_rst_grant got %b want 000", grant); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy); end
        checks++; if (data_out !== 24'd0) begin errors++; $display("FAIL mid_rst_data got %h want 000000", data_out); end
        checks++; if (en_out !== 4'd0)    begin errors++; $display("FAIL mid_rst_en got %h want 0", en_out); end
        rst = 1'b0;
        tick();
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL mid_regrant got %b want 001", grant); end
    endtask

    task automatic test_dwell_one();
        logic [2:0] exp_g;
        do_reset();
        req = 3'b111;
        for (int c = 0; c < 6; c++) begin
            tick();
            exp_g = 3'b001 << (c % 3);
            checks++; if (grant1 !== exp_g) begin errors++; $display("FAIL dwell1_grant cycle %0d got %b want %b", c, grant1, exp_g); end
            checks++; if (busy1 !== 1'b1)   begin errors++; $display("FAIL dwell1_busy cycle %0d got %b want 1", c, busy1); end
        end
        req = 3'b010;
        tick();
        tick();
        checks++; if (grant1 !== 3'b010) begin errors++; $display("FAIL dwell1_solo got %b want 010", grant1); end
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_round_robin();
        test_owner_drop();
        test_single_owner();
        test_all_drop();
        test_reset_mid_hold();
        test_dwell_one();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule
